// File: rtl/spike_vote_argmax_pkg.sv
// Shared configuration and FSM encoding for the spike vote / argmax block.
// Optional margin output is enabled with SPIKE_VOTE_MARGIN_EN.
package spike_vote_argmax_pkg;

  localparam int unsigned SVA_NUM_CLASSES = 10;
  localparam int unsigned SVA_CLASS_W     = 4;
  localparam int unsigned SVA_COUNT_W     = 8;
  localparam int unsigned SVA_ITER_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } sva_state_e;

  // Busy covers both the accumulation and the argmax scan phases.
  function automatic logic state_is_busy(input sva_state_e st);
    return (st == ST_ACCUM) || (st == ST_SCAN);
  endfunction

endpackage

// File: rtl/spike_vote_argmax_sat_counter.sv
// Per-class spike counter: synchronous clear, increment, saturates at all-ones.
module spike_vote_argmax_sat_counter #(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [COUNT_W-1:0] count_o
);

  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clock_i) begin
    if (reset_i || clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/spike_vote_argmax.sv
// Tallies per-class spikes over num_iter iterations, then scans for the winning class.
// Define SPIKE_VOTE_MARGIN_EN to add result_margin (winner minus runner-up).
module spike_vote_argmax
  import spike_vote_argmax_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = SVA_NUM_CLASSES,
  parameter int unsigned CLASS_W     = SVA_CLASS_W,
  parameter int unsigned COUNT_W     = SVA_COUNT_W,
  parameter int unsigned ITER_W      = SVA_ITER_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [ITER_W-1:0]  num_iter,
  input  logic               spike_valid,
  input  logic               spike,
  input  logic [CLASS_W-1:0] class_id,
  input  logic               iter_done,
  output logic               busy,
  output logic               result_valid,
  output logic [CLASS_W-1:0] result_class,
  output logic [COUNT_W-1:0] result_count,
  output logic               tie,
  output logic               err
`ifdef SPIKE_VOTE_MARGIN_EN
  ,
  output logic [COUNT_W-1:0] result_margin
`endif
);

  sva_state_e         state_q, state_d;
  logic [ITER_W-1:0]  iter_cnt_q;
  logic [ITER_W-1:0]  num_iter_q;
  logic [CLASS_W-1:0] scan_idx_q;
  logic [CLASS_W-1:0] best_idx_q;
  logic [COUNT_W-1:0] best_cnt_q;
  logic               best_tie_q;
  logic               busy_q;
  logic               result_valid_q;
  logic [CLASS_W-1:0] result_class_q;
  logic [COUNT_W-1:0] result_count_q;
  logic               tie_q;
  logic               err_q;
`ifdef SPIKE_VOTE_MARGIN_EN
  logic [COUNT_W-1:0] second_cnt_q;
  logic [COUNT_W-1:0] result_margin_q;
`endif

  logic                     class_ok_c;
  logic                     in_accum_c;
  logic                     last_iter_c;
  logic                     scan_last_c;
  logic                     spike_inc_c;
  logic                     err_event_c;
  logic [NUM_CLASSES-1:0]   inc_c;
  logic [COUNT_W-1:0]       class_cnt [NUM_CLASSES];
  logic [COUNT_W-1:0]       cur_cnt_c;

  assign class_ok_c  = {1'b0, class_id} < (CLASS_W+1)'(NUM_CLASSES);
  assign in_accum_c  = (state_q == ST_ACCUM);
  assign last_iter_c = (ITER_W'(iter_cnt_q + ITER_W'(1)) == num_iter_q);
  assign scan_last_c = (scan_idx_q == CLASS_W'(NUM_CLASSES - 1));
  assign spike_inc_c = in_accum_c && !start && spike_valid && spike && class_ok_c;

  // Out-of-range classes and events arriving outside accumulation are flagged.
  assign err_event_c = (spike_valid && !class_ok_c) ||
                       ((spike_valid || iter_done) && !in_accum_c);

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cnt
    assign inc_c[g] = spike_inc_c && (class_id == CLASS_W'(g));

    spike_vote_argmax_sat_counter #(
      .COUNT_W (COUNT_W)
    ) u_cnt (
      .clock_i (clock),
      .reset_i (reset),
      .clr_i   (start),
      .inc_i   (inc_c[g]),
      .count_o (class_cnt[g])
    );
  end

  // Read port for the sequential scan.
  always_comb begin
    cur_cnt_c = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (scan_idx_q == CLASS_W'(i)) cur_cnt_c = class_cnt[i];
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: if (iter_done && last_iter_c) state_d = ST_SCAN;
        ST_SCAN:  if (scan_last_c) state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      iter_cnt_q     <= '0;
      num_iter_q     <= '0;
      scan_idx_q     <= '0;
      best_idx_q     <= '0;
      best_cnt_q     <= '0;
      best_tie_q     <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_class_q <= '0;
      result_count_q <= '0;
      tie_q          <= 1'b0;
      err_q          <= 1'b0;
`ifdef SPIKE_VOTE_MARGIN_EN
      second_cnt_q    <= '0;
      result_margin_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= state_is_busy(state_d);
      if (start) begin
        iter_cnt_q     <= '0;
        num_iter_q     <= (num_iter == '0) ? ITER_W'(1) : num_iter;
        scan_idx_q     <= '0;
        best_idx_q     <= '0;
        best_cnt_q     <= '0;
        best_tie_q     <= 1'b0;
        result_valid_q <= 1'b0;
        result_class_q <= '0;
        result_count_q <= '0;
        tie_q          <= 1'b0;
        err_q          <= 1'b0;
`ifdef SPIKE_VOTE_MARGIN_EN
        second_cnt_q    <= '0;
        result_margin_q <= '0;
`endif
      end else begin
        if (err_event_c) err_q <= 1'b1;
        case (state_q)
          ST_ACCUM: begin
            scan_idx_q <= '0;
            if (iter_done) iter_cnt_q <= ITER_W'(iter_cnt_q + ITER_W'(1));
          end
          ST_SCAN: begin
            scan_idx_q <= CLASS_W'(scan_idx_q + CLASS_W'(1));
            // Strict greater-than keeps the lowest index on equal counts.
            if (scan_idx_q == '0) begin
              best_idx_q <= '0;
              best_cnt_q <= cur_cnt_c;
              best_tie_q <= 1'b0;
`ifdef SPIKE_VOTE_MARGIN_EN
              second_cnt_q <= '0;
`endif
            end else if (cur_cnt_c > best_cnt_q) begin
              best_idx_q <= scan_idx_q;
              best_cnt_q <= cur_cnt_c;
              best_tie_q <= 1'b0;
`ifdef SPIKE_VOTE_MARGIN_EN
              second_cnt_q <= best_cnt_q;
`endif
            end else if (cur_cnt_c == best_cnt_q) begin
              best_tie_q <= 1'b1;
`ifdef SPIKE_VOTE_MARGIN_EN
              second_cnt_q <= cur_cnt_c;
`endif
            end else begin
`ifdef SPIKE_VOTE_MARGIN_EN
              if (cur_cnt_c > second_cnt_q) second_cnt_q <= cur_cnt_c;
`endif
            end
          end
          ST_DONE: begin
            result_valid_q <= 1'b1;
            result_class_q <= best_idx_q;
            result_count_q <= best_cnt_q;
            tie_q          <= best_tie_q;
`ifdef SPIKE_VOTE_MARGIN_EN
            result_margin_q <= best_tie_q ? '0 : COUNT_W'(best_cnt_q - second_cnt_q);
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result_class = result_class_q;
  assign result_count = result_count_q;
  assign tie          = tie_q;
  assign err          = err_q;
`ifdef SPIKE_VOTE_MARGIN_EN
  assign result_margin = result_margin_q;
`endif

endmodule

// File: tb/tb_spike_vote_argmax.sv
// Self-checking bench for spike_vote_argmax: behavioural vote model plus directed literal cases.
module tb_spike_vote_argmax;

  localparam int NC  = 10;
  localparam int CW  = 4;
  localparam int KW  = 8;
  localparam int IW  = 8;
  localparam int SAT = (1 << KW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] num_iter = '0;
  logic          spike_valid = 1'b0;
  logic          spike = 1'b0;
  logic [CW-1:0] class_id = '0;
  logic          iter_done = 1'b0;
  logic          busy, result_valid, tie, err;
  logic [CW-1:0] result_class;
  logic [KW-1:0] result_count;
`ifdef SPIKE_VOTE_MARGIN_EN
  logic [KW-1:0] result_margin;
`endif

  always #5 clock = ~clock;

  spike_vote_argmax dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .num_iter     (num_iter),
    .spike_valid  (spike_valid),
    .spike        (spike),
    .class_id     (class_id),
    .iter_done    (iter_done),
    .busy         (busy),
    .result_valid (result_valid),
    .result_class (result_class),
    .result_count (result_count),
    .tie          (tie),
    .err          (err)
`ifdef SPIKE_VOTE_MARGIN_EN
    ,
    .result_margin(result_margin)
`endif
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  // Model: phase of a run, tallies, and edges elapsed since the final iteration.
  typedef enum {M_IDLE, M_ACCUM, M_POST} mmode_e;
  mmode_e m_mode = M_IDLE;
  int     m_cnt [NC];
  int     m_iters = 0, m_target = 1, m_since = 0;
  bit     m_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void ref_result(output int cls, output int cnt, output bit t, output int mg);
    int sec;
    cls = 0; cnt = m_cnt[0]; t = 0; sec = 0;
    for (int i = 1; i < NC; i++) if (m_cnt[i] > cnt) begin cnt = m_cnt[i]; cls = i; end
    for (int i = 0; i < NC; i++) if (i != cls) begin
      if (m_cnt[i] == cnt) t = 1;
      if (m_cnt[i] > sec) sec = m_cnt[i];
    end
    mg = t ? 0 : cnt - sec;
  endfunction

  function automatic void model_update(input bit r, input bit s, input int ni, input bit sv,
                                       input bit sp, input int cid, input bit idn);
    if (r) begin
      m_mode = M_IDLE; m_iters = 0; m_since = 0; m_err = 0;
      for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    end else if (s) begin
      m_mode = M_ACCUM; m_iters = 0; m_since = 0; m_err = 0;
      m_target = (ni == 0) ? 1 : ni;
      for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    end else begin
      if ((sv && cid >= NC) || ((sv || idn) && m_mode != M_ACCUM)) m_err = 1;
      if (m_mode == M_ACCUM) begin
        if (sv && sp && cid < NC && m_cnt[cid] < SAT) m_cnt[cid]++;
        if (idn) begin
          m_iters++;
          if (m_iters == m_target) begin m_mode = M_POST; m_since = 0; end
        end
      end else if (m_mode == M_POST) begin
        m_since++;
      end
    end
  endfunction

  task automatic step(input bit s, input int ni, input bit sv, input bit sp, input int cid, input bit idn);
    start = s; num_iter = IW'(ni); spike_valid = sv; spike = sp; class_id = CW'(cid); iter_done = idn;
    @(posedge clock);
    #1;
    model_update(reset, s, ni, sv, sp, cid, idn);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic spk(input int cid);
    step(0, 0, 1, 1, cid, 0);
  endtask

  // Idles until result_valid rises; returns edges waited, bounded.
  task automatic wait_rv(output int n);
    n = 0;
    while (result_valid !== 1'b1 && n < 40) begin idle(); n++; end
    if (n >= 40) begin
      checks++; failures++;
      $display("FAIL wait_rv timeout actual=%0d required=11", n);
    end
  endtask

  // Single compare process against the model, every cycle.
  always @(negedge clock) begin
    int rc, rn, mg;
    bit rt, vis;
    if (chk_en) begin
      vis = (m_mode == M_POST) && (m_since >= 11);
      ref_result(rc, rn, rt, mg);
      chk("busy", int'(busy), int'((m_mode == M_ACCUM) || (m_mode == M_POST && m_since < 10)));
      chk("result_valid", int'(result_valid), int'(vis));
      chk("result_class", int'(result_class), vis ? rc : 0);
      chk("result_count", int'(result_count), vis ? rn : 0);
      chk("tie", int'(tie), vis ? int'(rt) : 0);
      chk("err", int'(err), int'(m_err));
`ifdef SPIKE_VOTE_MARGIN_EN
      chk("result_margin", int'(result_margin), vis ? mg : 0);
`endif
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, eff, nspk;
    bit abort;
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    reset = 1'b1;
    idle(); idle();
    reset = 1'b0;
    chk_en = 1;
    chk("reset busy", int'(busy), 0);
    chk("reset result_valid", int'(result_valid), 0);
    chk("reset err", int'(err), 0);

    // Basic vote: class 7 x3, class 2 x1 over 3 iterations.
    step(1, 3, 0, 0, 0, 0);
    spk(7); spk(2); step(0, 0, 0, 0, 0, 1);
    spk(7); step(0, 0, 0, 0, 0, 1);
    spk(7); step(0, 0, 0, 0, 0, 1);
    wait_rv(n);
    chk("basic latency", n, 11);
    chk("basic class", int'(result_class), 7);
    chk("basic count", int'(result_count), 3);
    chk("basic tie", int'(tie), 0);
    idle(); idle();
    chk("basic hold", int'(result_valid), 1);

    // Tie between classes 4 and 6, 5 spikes each.
    step(1, 5, 0, 0, 0, 0);
    for (int it = 0; it < 5; it++) begin spk(4); spk(6); step(0, 0, 0, 0, 0, 1); end
    wait_rv(n);
    chk("tie class", int'(result_class), 4);
    chk("tie count", int'(result_count), 5);
    chk("tie flag", int'(tie), 1);

    // Saturation: 260 spikes to class 1.
    step(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 260; k++) spk(1);
    step(0, 0, 0, 0, 0, 1);
    wait_rv(n);
    chk("sat class", int'(result_class), 1);
    chk("sat count", int'(result_count), 255);

    // Spike on class 9 coincident with the final iter_done is counted.
    step(1, 2, 0, 0, 0, 0);
    spk(9); step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 9, 1);
    wait_rv(n);
    chk("coincident latency", n, 11);
    chk("coincident class", int'(result_class), 9);
    chk("coincident count", int'(result_count), 2);

    // Restart during SCAN, then a num_iter=0 run.
    step(1, 1, 0, 0, 0, 0);
    spk(3); step(0, 0, 0, 0, 0, 1);
    idle(); idle(); idle(); idle();
    step(1, 0, 1, 1, 5, 1);
    chk("restart busy", int'(busy), 1);
    chk("restart result_valid", int'(result_valid), 0);
    chk("restart count", int'(result_count), 0);
    step(0, 0, 0, 0, 0, 1);
    wait_rv(n);
    chk("zero-iter latency", n, 11);
    chk("all-zero class", int'(result_class), 0);
    chk("all-zero count", int'(result_count), 0);
    chk("all-zero tie", int'(tie), 1);

    // Out-of-range class flags err without touching counters.
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 1, 12, 0);
    chk("err set", int'(err), 1);
    step(0, 0, 0, 0, 0, 1); step(0, 0, 0, 0, 0, 1);
    wait_rv(n);
    chk("err count", int'(result_count), 0);
    chk("err sticky", int'(err), 1);
    step(1, 1, 0, 0, 0, 0);
    chk("err cleared", int'(err), 0);

    // Randomized runs with occasional aborts, invalid classes and stray events.
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(0, 4);
      eff = (n == 0) ? 1 : n;
      abort = ($urandom % 5 == 0);
      step(1, n, 0, 0, 0, 0);
      for (int it = 0; it < eff; it++) begin
        if (abort && it == eff - 1) break;
        nspk = $urandom_range(0, 12);
        for (int k = 0; k < nspk; k++)
          step(0, 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
               ($urandom % 12 == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9)), 0);
        step(0, 0, $urandom % 2, 1, $urandom_range(0, 9), 1);
      end
      if (!abort) begin
        for (int k = 0; k < 14; k++)
          step(0, 0, ($urandom % 8) == 0, 1, $urandom_range(0, 9), ($urandom % 16) == 0);
      end
    end
    idle(); idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
